xadc_sensor_reader: RTL and testbench
=====================================

# xadc_sensor_reader

Upstream feeder for the seven-segment display driver in the XADC demo. Periodically reads one on-chip sensor (die temperature, VCCINT or VCCAUX) over the XADC DRP port and averages 16 samples. It scales the average to decimal display units and presents the `din`, `bcd` and `dec` values the display driver consumes, plus an update strobe and an error flag.

## Interface
- `SAMPLE_DIV`, 100000: clk cycles between DRP read requests (≥ 2).
- `TIMEOUT`, 255: max clk cycles to wait for `drdy` after a request (1..255).
- `clk`  in  1  system clock; sole clock domain.
- `rst_n`  in  1  reset, asynchronous assert, active-low; all state cleared while low.
- `chan`  in  2  sensor select: 0 = temperature, 1 = VCCINT, 2 = VCCAUX, 3 = treated as 0.
- `daddr`  out  7  DRP address: 7'h00 / 7'h01 / 7'h02 per channel.
- `den`  out  1  DRP enable, one-cycle pulse per read.
- `dwe`  out  1  DRP write enable, constant 0.
- `di`  out  16  DRP write data, constant 0.
- `do`  in  16  DRP read data; 12-bit result in `do[15:4]`.
- `drdy`  in  1  DRP read-data-valid strobe.
- `din`  out  16  display value (BCD-convertible binary, or 16'hEEEE on error).
- `bcd`  out  1  1 = driver shows `din` as decimal; 0 = hex.
- `dec`  out  2  decimal-point position code for the driver.
- `valid`  out  1  one-cycle pulse when `din`/`bcd`/`dec` update.
- `err`  out  1  DRP timeout seen; cleared by the next completed average.

## Operation
- Reset values: `din`=0, `bcd`=1, `dec`=2'b00, `valid`=0, `err`=0, `den`=0, `daddr`=0, accumulator=0, sample count=0, period counter=0, state IDLE.
- Period counter runs freely modulo `SAMPLE_DIV` in every state. A tick is raised when it wraps to 0.
- FSM states and transitions:
  - IDLE: on tick → REQ.
  - REQ: `daddr` set from the channel latched at entry; `den`=1 for this single cycle → WAIT.
  - WAIT: `drdy`=1 → ACC. Timeout counter reaches `TIMEOUT` → ERR.
  - ACC: adds `do[15:4]` (captured at the `drdy` edge) to the 16-bit accumulator and increments the count. If count becomes 16 → SCALE, else → IDLE.
  - SCALE: computes avg = acc[15:4] and the scaled result → OUT.
  - OUT: registers the outputs, pulses `valid`, clears the accumulator, count and `err` → IDLE.
  - ERR: `din`=16'hEEEE, `bcd`=0, `dec`=2'b00, `err`=1, `valid` pulsed, accumulator and count cleared → IDLE.
- `daddr` is held stable from REQ through WAIT.
- A `drdy` arriving outside WAIT is ignored. Ticks outside IDLE are dropped, not queued.
- Scaling, using ≥ 21-bit intermediates:
  - Temperature in tenths of °C: t = ((avg × 315) >> 8) − 2732. Result clamped to 0 if negative; `dec`=2'b01.
  - VCCINT/VCCAUX in mV: v = (avg × 375) >> 9; `dec`=2'b11 so the display reads x.xxx V.
  - Both results are ≤ 5038 and fit 4 BCD digits; `bcd`=1.
- Channel change: `chan` is compared with the latched channel on entry to REQ. If different, the accumulator and count are cleared before the new read. Outputs keep their old values until 16 samples of the new channel have completed.
- `rst_n` low mid-transaction aborts it immediately. A `drdy` arriving after reset release is ignored, since the FSM is in IDLE.

## Timing
- `den` is high exactly one cycle per request. No new request is issued while in WAIT.
- The timeout counter starts at 0 in the first WAIT cycle. ERR is entered after `TIMEOUT` WAIT cycles without `drdy`.
- Latency: on the 16th sample, `din`/`bcd`/`dec` change and `valid` is high in the cycle following the 3rd rising edge after the edge sampling `drdy`. The path is ACC, SCALE, OUT.
- Worst-case time from request to done is `TIMEOUT`+4 cycles, which is below `SAMPLE_DIV` for the defaults.
- Outputs are registered and hold their value between updates.

## Test plan
- Reset: hold `rst_n`=0 with `drdy` toggling → all outputs at their reset values and `den` never high. Release → first `den` appears one cycle after the first tick.
- Temperature: `chan`=0, DRP model returns `do`=16'h9600 (code 2400) with 2-cycle latency, 16 reads → `din`=221, `bcd`=1, `dec`=2'b01, single-cycle `valid`, `daddr`=7'h00.
- VCCINT: `chan`=1, code 1365 (`do`=16'h5550) → `din`=999, `dec`=2'b11, `daddr`=7'h01. Code 4095 → `din`=2999.
- Clamp: `chan`=0, code 100 → `din`=0, with no wrap to a large value.
- Timeout: DRP model never asserts `drdy` → exactly `TIMEOUT` WAIT cycles, then `err`=1, `din`=16'hEEEE, `bcd`=0, `valid` pulse. Next 16 good reads → `err`=0 with the correct value.
- Channel switch after 8 temperature samples to `chan`=2 → the average uses only 16 fresh VCCAUX samples. Reset asserted during WAIT → clean restart, and a late `drdy` is ignored.

Source files
------------

// File: rtl/xadc_sensor_reader_if.sv
// DRP bus between the sensor reader (master) and the XADC primitive (slave).
interface xadc_sensor_reader_if;
  logic [6:0]  daddr;
  logic        den;
  logic        dwe;
  logic [15:0] di;
  logic [15:0] do_data;  // XADC DO pin; "do" itself is a reserved word
  logic        drdy;

  modport master (output daddr, den, dwe, di, input do_data, drdy);
  modport slave  (input daddr, den, dwe, di, output do_data, drdy);
endinterface

// File: rtl/xadc_sensor_reader.sv
// Periodically reads one XADC sensor over DRP, averages 16 samples and
// scales the average to decimal display units for the seven-segment driver.
module xadc_sensor_reader #(
  parameter int SAMPLE_DIV = 100000,
  parameter int TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           chan,
  xadc_sensor_reader_if.master drp,
  output logic [15:0]          din,
  output logic                 bcd,
  output logic [1:0]           dec,
  output logic                 valid,
  output logic                 err
);

  localparam int             DIV_W    = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [7:0]     TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_ACC, S_SCALE, S_OUT, S_ERR
  } state_t;

  state_t             state, state_next;
  logic [DIV_W-1:0]   period_cnt;
  logic               tick;
  logic [7:0]         tmo_cnt;
  logic [1:0]         cur_chan;
  logic [6:0]         daddr_q;
  logic [11:0]        sample;
  logic [15:0]        acc;
  logic [4:0]         count;
  logic [15:0]        result;
  logic [1:0]         res_dec;

  // Channel 3 is an alias for the temperature sensor.
  logic [1:0] chan_sel;
  assign chan_sel = (chan == 2'd3) ? 2'd0 : chan;

  // Scaling arithmetic on the 16-sample average (21-bit products).
  logic [11:0] avg;
  logic [20:0] temp_prod;
  logic [20:0] volt_prod;
  logic [12:0] temp_raw;
  logic [12:0] temp_c;
  logic [11:0] volt_mv;

  assign avg       = acc[15:4];
  assign temp_prod = 21'(avg) * 21'd315;
  assign volt_prod = 21'(avg) * 21'd375;
  assign temp_raw  = temp_prod[20:8];
  assign temp_c    = (temp_raw > 13'd2732) ? (temp_raw - 13'd2732) : 13'd0;
  assign volt_mv   = volt_prod[20:9];

  // Low status nibble of DO and the fractional product bits are discarded.
  logic unused_bits;
  assign unused_bits = ^{drp.do_data[3:0], temp_prod[7:0], volt_prod[8:0]};

  assign drp.daddr = daddr_q;
  assign drp.dwe   = 1'b0;
  assign drp.di    = 16'h0000;

  // Free-running sample-period counter; tick marks each wrap to zero.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
      tick       <= 1'b0;
    end else begin
      tick       <= (period_cnt == DIV_LAST);
      period_cnt <= (period_cnt == DIV_LAST) ? '0 : period_cnt + DIV_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state decode and DRP enable.
  // NOTE: every output of this block gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    drp.den    = 1'b0;
    case (state)
      S_IDLE:  if (tick) state_next = S_REQ;
      S_REQ: begin
        drp.den    = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (drp.drdy)                state_next = S_ACC;
        else if (tmo_cnt == TMO_LAST) state_next = S_ERR;
      end
      S_ACC:   state_next = (count == 5'd15) ? S_SCALE : S_IDLE;
      S_SCALE: state_next = S_OUT;
      S_OUT:   state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: channel latch, sample capture, accumulation and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt  <= '0;
      cur_chan <= 2'd0;
      daddr_q  <= 7'h00;
      sample   <= '0;
      acc      <= '0;
      count    <= '0;
      result   <= '0;
      res_dec  <= 2'b00;
      din      <= 16'h0000;
      bcd      <= 1'b1;
      dec      <= 2'b00;
      valid    <= 1'b0;
      err      <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tick) begin
            // A new channel restarts the average from scratch.
            if (chan_sel != cur_chan) begin
              acc   <= '0;
              count <= '0;
            end
            cur_chan <= chan_sel;
            daddr_q  <= {5'd0, chan_sel};
          end
        end
        S_REQ: tmo_cnt <= '0;
        S_WAIT: begin
          if (drp.drdy) sample <= drp.do_data[15:4];
          tmo_cnt <= tmo_cnt + 8'd1;
        end
        S_ACC: begin
          acc   <= acc + 16'(sample);
          count <= count + 5'd1;
        end
        S_SCALE: begin
          if (cur_chan == 2'd0) begin
            result  <= 16'(temp_c);
            res_dec <= 2'b01;
          end else begin
            result  <= 16'(volt_mv);
            res_dec <= 2'b11;
          end
        end
        S_OUT: begin
          din   <= result;
          dec   <= res_dec;
          bcd   <= 1'b1;
          err   <= 1'b0;
          valid <= 1'b1;
          acc   <= '0;
          count <= '0;
        end
        S_ERR: begin
          din   <= 16'hEEEE;
          dec   <= 2'b00;
          bcd   <= 1'b0;
          err   <= 1'b1;
          valid <= 1'b1;
          acc   <= '0;
          count <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xadc_sensor_reader.sv
// Self-checking bench for xadc_sensor_reader: a DRP responder model plus a
// reference that averages and scales sensor codes with plain integer math.
module tb_xadc_sensor_reader;

  localparam int SD = 40;
  localparam int TO = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  chan;
  logic [15:0] din;
  logic        bcd;
  logic [1:0]  dec;
  logic        valid;
  logic        err;

  always #5 clk = ~clk;

  xadc_sensor_reader_if drp ();

  xadc_sensor_reader #(.SAMPLE_DIV(SD), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .chan  (chan),
    .drp   (drp),
    .din   (din),
    .bcd   (bcd),
    .dec   (dec),
    .valid (valid),
    .err   (err)
  );

  int          n_checks    = 0;
  int          n_errors    = 0;
  int          stray_valid = 0;
  bit          den_pending = 0;
  logic [11:0] codes [16];
  logic [3:0]  nibs  [16];

  // Reference: truncated 16-sample mean, then the display scaling rules.
  function automatic int ref_value(input int ch, input int sum);
    int avg;
    int t;
    avg = sum / 16;
    if (ch == 1 || ch == 2) return (avg * 375) / 512;
    t = (avg * 315) / 256 - 2732;
    return (t < 0) ? 0 : t;
  endfunction

  function automatic logic [1:0] ref_dec(input int ch);
    return (ch == 1 || ch == 2) ? 2'b11 : 2'b01;
  endfunction

  // Wait (bounded) for a DRP request; n = negedges observed until den.
  task automatic wait_den(output int n, output bit ok);
    ok = 0;
    n  = 0;
    while (n < 3 * SD) begin
      @(negedge clk);
      n++;
      if (valid) stray_valid++;
      if (drp.den) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL den_timeout: no den within %0d cycles", 3 * SD);
    end
  endtask

  // Answer the request just seen with drdy after lat cycles.
  task automatic respond(input logic [11:0] code, input logic [3:0] nib,
                         input int lat, input logic [6:0] addr);
    n_checks++;
    if (drp.daddr !== addr) begin
      n_errors++;
      $display("FAIL daddr_req: got %0h expected %0h", drp.daddr, addr);
    end
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      if (i == 0) begin
        n_checks++;
        if (drp.den !== 1'b0) begin
          n_errors++;
          $display("FAIL den_width: den still %b in cycle after request", drp.den);
        end
      end
    end
    n_checks++;
    if (drp.daddr !== addr) begin
      n_errors++;
      $display("FAIL daddr_hold: got %0h expected %0h", drp.daddr, addr);
    end
    drp.drdy    = 1'b1;
    drp.do_data = {code, nib};
    @(negedge clk);
    drp.drdy    = 1'b0;
    drp.do_data = 16'($urandom);
  endtask

  // Serve 16 reads from codes[]/nibs[] and check the resulting update.
  task automatic run_avg(input string name, input int ch, input int lat);
    int          n;
    bit          ok;
    int          sum;
    logic [6:0]  addr;
    logic [15:0] e_din;
    logic [1:0]  e_dec;
    chan = 2'(ch);
    addr = (ch == 1 || ch == 2) ? 7'(ch) : 7'h00;
    sum  = 0;
    for (int i = 0; i < 16; i++) sum += int'(codes[i]);
    e_din = 16'(ref_value(ch, sum));
    e_dec = ref_dec(ch);
    for (int i = 0; i < 16; i++) begin
      if (den_pending) begin
        den_pending = 0;
      end else begin
        wait_den(n, ok);
        if (!ok) return;
      end
      respond(codes[i], nibs[i], lat, addr);
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      n_checks++;
      if (valid !== 1'b0) begin
        n_errors++;
        $display("FAIL %s early_valid: valid=%b at %0d cycles after drdy", name, valid, k + 1);
      end
    end
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b1) begin
      n_errors++;
      $display("FAIL %s valid: got %b expected 1", name, valid);
    end
    n_checks++;
    if (din !== e_din) begin
      n_errors++;
      $display("FAIL %s din: got %0d expected %0d", name, din, e_din);
    end
    n_checks++;
    if (dec !== e_dec || bcd !== 1'b1 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL %s flags: got dec=%b bcd=%b err=%b expected dec=%b bcd=1 err=0",
               name, dec, bcd, err, e_dec);
    end
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0) begin
      n_errors++;
      $display("FAIL %s valid_width: got %b expected 0", name, valid);
    end
  endtask

  task automatic fill(input logic [11:0] a, input logic [11:0] b);
    for (int i = 0; i < 16; i++) begin
      codes[i] = (i < 8) ? a : b;
      nibs[i]  = 4'h0;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      codes[i] = 12'($urandom_range(0, 4095));
      nibs[i]  = 4'($urandom);
    end
  endtask

  task automatic test_reset();
    bit den_seen;
    int n;
    bit ok;
    den_seen    = 0;
    rst_n       = 1'b0;
    chan        = 2'd0;
    drp.drdy    = 1'b0;
    drp.do_data = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drp.drdy    = ~drp.drdy;
      drp.do_data = 16'($urandom);
      if (drp.den) den_seen = 1;
    end
    n_checks++;
    if (den_seen) begin
      n_errors++;
      $display("FAIL reset_den: den seen=%b expected 0", den_seen);
    end
    n_checks++;
    if (din !== 16'h0000 || bcd !== 1'b1 || dec !== 2'b00 || valid !== 1'b0 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got din=%0h bcd=%b dec=%b valid=%b err=%b expected 0/1/00/0/0",
               din, bcd, dec, valid, err);
    end
    n_checks++;
    if (drp.daddr !== 7'h00 || drp.dwe !== 1'b0 || drp.di !== 16'h0000) begin
      n_errors++;
      $display("FAIL reset_drp: got daddr=%0h dwe=%b di=%0h expected 0/0/0", drp.daddr, drp.dwe, drp.di);
    end
    drp.drdy = 1'b0;
    rst_n    = 1'b1;
    wait_den(n, ok);
    if (ok) begin
      n_checks++;
      if (n !== SD + 1) begin
        n_errors++;
        $display("FAIL first_den: got %0d cycles after release expected %0d", n, SD + 1);
      end
      den_pending = 1;
    end
  endtask

  task automatic test_temperature();
    fill(12'd2400, 12'd2400);
    run_avg("temp_2400", 0, 2);
  endtask

  task automatic test_vccint();
    fill(12'd1365, 12'd1365);
    run_avg("vccint_1365", 1, 2);
    fill(12'd4095, 12'd4095);
    run_avg("vccint_4095", 1, 3);
  endtask

  task automatic test_clamp();
    fill(12'd100, 12'd100);
    run_avg("clamp_100", 0, 1);
    fill(12'd2222, 12'd2223);
    run_avg("temp_near_zero", 0, 1);
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    int k;
    bit found;
    chan = 2'd0;
    wait_den(n, ok);
    if (!ok) return;
    k     = 0;
    found = 0;
    while (k < TO + 10) begin
      @(negedge clk);
      k++;
      if (valid) begin
        found = 1;
        break;
      end
    end
    n_checks++;
    if (!found || k !== TO + 2) begin
      n_errors++;
      $display("FAIL timeout_latency: valid after %0d cycles (found=%b) expected %0d", k, found, TO + 2);
    end
    n_checks++;
    if (err !== 1'b1 || din !== 16'hEEEE || bcd !== 1'b0 || dec !== 2'b00) begin
      n_errors++;
      $display("FAIL timeout_outputs: got err=%b din=%0h bcd=%b dec=%b expected 1/eeee/0/00",
               err, din, bcd, dec);
    end
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0 || err !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_hold: got valid=%b err=%b expected 0/1", valid, err);
    end
    fill_random();
    run_avg("timeout_recover", 0, 2);
  endtask

  task automatic test_channel_switch();
    int n;
    bit ok;
    chan = 2'd0;
    for (int i = 0; i < 8; i++) begin
      wait_den(n, ok);
      if (!ok) return;
      respond(12'($urandom_range(0, 4095)), 4'($urandom), 2, 7'h00);
    end
    fill_random();
    run_avg("switch_vccaux", 2, 2);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      fill_random();
      run_avg("random", $urandom_range(0, 3), $urandom_range(1, TO - 1));
    end
  endtask

  task automatic test_reset_mid_wait();
    int n;
    bit ok;
    chan = 2'd1;
    wait_den(n, ok);
    if (!ok) return;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (din !== 16'h0000 || bcd !== 1'b1 || valid !== 1'b0 || err !== 1'b0 ||
        drp.den !== 1'b0 || drp.daddr !== 7'h00) begin
      n_errors++;
      $display("FAIL midwait_reset: got din=%0h bcd=%b valid=%b err=%b den=%b daddr=%0h",
               din, bcd, valid, err, drp.den, drp.daddr);
    end
    chan = 2'd2;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drp.drdy    = 1'b1;
    drp.do_data = 16'hFFF0;
    @(negedge clk);
    drp.drdy = 1'b0;
    wait_den(n, ok);
    if (!ok) return;
    n_checks++;
    if (n !== SD - 1 || din !== 16'h0000) begin
      n_errors++;
      $display("FAIL late_drdy: got den after %0d cycles din=%0h expected %0d cycles din=0",
               n, din, SD - 1);
    end
    den_pending = 1;
    fill_random();
    run_avg("after_reset", 2, 2);
  endtask

  initial begin
    test_reset();
    test_temperature();
    test_vccint();
    test_clamp();
    test_timeout();
    test_channel_switch();
    test_random();
    test_reset_mid_wait();
    n_checks++;
    if (stray_valid !== 0) begin
      n_errors++;
      $display("FAIL stray_valid: got %0d unexpected pulses expected 0", stray_valid);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
